// File: rtl/rice_partition_sequencer.sv
// rtl/rice_partition_sequencer.sv - walks a Rice-coded residual block partition by partition
// Issues one registered operand set per accepted residual to a 1-cycle demapper.
module rice_partition_sequencer (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [15:0] iBlockSize,
  input  logic [3:0]  iPartOrder,
  input  logic [5:0]  iPredOrder,
  input  logic        iParamValid,
  input  logic [3:0]  iRiceParam,
  output logic        oParamReady,
  input  logic        iResValid,
  input  logic [15:0] iMSB,
  input  logic [15:0] iLSB,
  output logic        oResReady,
  output logic        oOpValid,
  output logic [15:0] oMSB,
  output logic [15:0] oLSB,
  output logic [3:0]  oRiceParam,
  output logic        oSampleValid,
  output logic [14:0] oPartIdx,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError
);

  typedef enum logic [1:0] {ST_IDLE, ST_PARAM, ST_RESID, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  part_order_q, part_order_d;
  logic [5:0]  pred_order_q, pred_order_d;
  logic [15:0] part_len_q, part_len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [14:0] part_idx_q, part_idx_d;
  logic [3:0]  rice_q, rice_d;
  logic        op_valid_q, op_valid_d;
  logic [15:0] msb_q, msb_d;
  logic [15:0] lsb_q, lsb_d;
  logic [3:0]  op_rice_q, op_rice_d;
  logic        sample_valid_q, sample_valid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [15:0] start_mask, start_len, part_mask, param_len;
  logic        cfg_err, last_part;

  // Config check happens before any subtraction, so param_len never wraps.
  always_comb begin
    start_mask = ~(16'hFFFF << iPartOrder);
    start_len  = iBlockSize >> iPartOrder;
    cfg_err    = ((iBlockSize & start_mask) != 16'd0) || (start_len < {10'd0, iPredOrder});
    part_mask  = ~(16'hFFFF << part_order_q);
    last_part  = ({1'b0, part_idx_q} == part_mask);
    param_len  = (part_idx_q == 15'd0) ? (part_len_q - {10'd0, pred_order_q}) : part_len_q;
  end

  always_comb begin
    state_d        = state_q;
    part_order_d   = part_order_q;
    pred_order_d   = pred_order_q;
    part_len_d     = part_len_q;
    cnt_d          = cnt_q;
    part_idx_d     = part_idx_q;
    rice_d         = rice_q;
    op_valid_d     = 1'b0;
    msb_d          = msb_q;
    lsb_d          = lsb_q;
    op_rice_d      = op_rice_q;
    sample_valid_d = op_valid_q;
    // Delayed a cycle so it lines up with the final demapped sample.
    done_d         = (state_q == ST_DONE);
    error_d        = error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          part_order_d = iPartOrder;
          pred_order_d = iPredOrder;
          part_len_d   = start_len;
          part_idx_d   = 15'd0;
          error_d      = cfg_err;
          state_d      = cfg_err ? ST_DONE : ST_PARAM;
        end
      end
      ST_PARAM: begin
        if (iParamValid) begin
          if (iRiceParam == 4'hF) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            rice_d = iRiceParam;
            cnt_d  = param_len;
            if (param_len != 16'd0) begin
              state_d = ST_RESID;
            end else if (last_part) begin
              state_d = ST_DONE;
            end else begin
              part_idx_d = part_idx_q + 15'd1;
            end
          end
        end
      end
      ST_RESID: begin
        if (iResValid) begin
          op_valid_d = 1'b1;
          msb_d      = iMSB;
          lsb_d      = iLSB;
          op_rice_d  = rice_q;
          cnt_d      = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            if (last_part) begin
              state_d = ST_DONE;
            end else begin
              part_idx_d = part_idx_q + 15'd1;
              state_d    = ST_PARAM;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q        <= ST_IDLE;
      part_order_q   <= 4'd0;
      pred_order_q   <= 6'd0;
      part_len_q     <= 16'd0;
      cnt_q          <= 16'd0;
      part_idx_q     <= 15'd0;
      rice_q         <= 4'd0;
      op_valid_q     <= 1'b0;
      msb_q          <= 16'd0;
      lsb_q          <= 16'd0;
      op_rice_q      <= 4'd0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      part_order_q   <= part_order_d;
      pred_order_q   <= pred_order_d;
      part_len_q     <= part_len_d;
      cnt_q          <= cnt_d;
      part_idx_q     <= part_idx_d;
      rice_q         <= rice_d;
      op_valid_q     <= op_valid_d;
      msb_q          <= msb_d;
      lsb_q          <= lsb_d;
      op_rice_q      <= op_rice_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign oParamReady  = (state_q == ST_PARAM);
  assign oResReady    = (state_q == ST_RESID);
  assign oBusy        = (state_q != ST_IDLE);
  assign oOpValid     = op_valid_q;
  assign oMSB         = msb_q;
  assign oLSB         = lsb_q;
  assign oRiceParam   = op_rice_q;
  assign oSampleValid = sample_valid_q;
  assign oPartIdx     = part_idx_q;
  assign oDone        = done_q;
  assign oError       = error_q;

endmodule
